// File: rtl/pokey_reg_file.sv
//------------------------------------------------------------------------------
// pokey_reg_file : CPU-facing POKEY register bank (write latches, command
//                  strobes, IRQST latch, registered read mux).
// Optional serial path enabled by defining POKEY_SERIAL_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pokey_reg_file (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  ADDR,
  input  logic [7:0]  DATA_IN,
  input  logic        WR_EN,
  input  logic        RD_EN,
  output logic [7:0]  DATA_OUT,
  output logic [31:0] AUDF,
  output logic [31:0] AUDC,
  output logic [7:0]  AUDCTL,
  output logic [7:0]  SKCTL,
  output logic [7:0]  IRQEN,
  output logic [7:0]  SEROUT_DATA,
  output logic        STIMER_STB,
  output logic        SKREST_STB,
  output logic        POTGO_STB,
  output logic        SEROUT_STB,
  input  logic [7:0]  IRQ_EVENT,
  output logic        IRQ_N,
  input  logic [63:0] POT_IN,
  input  logic [7:0]  ALLPOT_IN,
  input  logic [7:0]  KBCODE_IN,
  input  logic [7:0]  RANDOM_IN,
  input  logic [7:0]  SERIN_IN,
  input  logic [7:0]  SKSTAT_IN
);

  logic [15:0] wr_sel;
  logic [31:0] audf_q, audf_d, audc_q, audc_d;
  logic [7:0]  audctl_q, skctl_q, irqen_q, irqen_d;
  logic [7:0]  irqst_q, irqst_d;
  logic        irq_n_q;
  logic [7:0]  dout_q, rd_mux;
  logic        stimer_q, potgo_q;
  logic [7:0]  serin_rd, skstat_rd;

  assign wr_sel = WR_EN ? (16'd1 << ADDR) : 16'd0;

  always_comb begin
    audf_d = audf_q;
    audc_d = audc_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_sel[2*k])   audf_d[8*k +: 8] = DATA_IN;
      if (wr_sel[2*k+1]) audc_d[8*k +: 8] = DATA_IN;
    end
  end

  // Events qualify on the old enable; the new enable forces disabled bits high.
  assign irqen_d = wr_sel[14] ? DATA_IN : irqen_q;
  assign irqst_d = (irqst_q & ~(IRQ_EVENT & irqen_q)) | ~irqen_d;

`ifdef POKEY_SERIAL_EN
  logic [7:0] serout_q;
  logic       skrest_q, serout_stb_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      serout_q     <= 8'h00;
      skrest_q     <= 1'b0;
      serout_stb_q <= 1'b0;
    end else begin
      if (wr_sel[13]) serout_q <= DATA_IN;
      skrest_q     <= wr_sel[10];
      serout_stb_q <= wr_sel[13];
    end
  end

  assign SEROUT_DATA = serout_q;
  assign SKREST_STB  = skrest_q;
  assign SEROUT_STB  = serout_stb_q;
  assign serin_rd    = SERIN_IN;
  assign skstat_rd   = SKSTAT_IN;
`else
  logic unused_serial;
  assign unused_serial = ^{SERIN_IN, SKSTAT_IN};
  assign SEROUT_DATA   = 8'h00;
  assign SKREST_STB    = 1'b0;
  assign SEROUT_STB    = 1'b0;
  assign serin_rd      = 8'hFF;
  assign skstat_rd     = 8'hFF;
`endif

  always_comb begin
    rd_mux = 8'hFF;
    case (ADDR)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7: rd_mux = POT_IN[{ADDR[2:0], 3'b000} +: 8];
      4'h8:    rd_mux = ALLPOT_IN;
      4'h9:    rd_mux = KBCODE_IN;
      4'hA:    rd_mux = RANDOM_IN;
      4'hD:    rd_mux = serin_rd;
      4'hE:    rd_mux = irqst_q;
      4'hF:    rd_mux = skstat_rd;
      default: rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      audf_q   <= 32'h0;
      audc_q   <= 32'h0;
      audctl_q <= 8'h00;
      skctl_q  <= 8'h00;
      irqen_q  <= 8'h00;
      irqst_q  <= 8'hFF;
      irq_n_q  <= 1'b1;
      dout_q   <= 8'hFF;
      stimer_q <= 1'b0;
      potgo_q  <= 1'b0;
    end else begin
      audf_q   <= audf_d;
      audc_q   <= audc_d;
      if (wr_sel[8])  audctl_q <= DATA_IN;
      if (wr_sel[15]) skctl_q  <= DATA_IN;
      irqen_q  <= irqen_d;
      irqst_q  <= irqst_d;
      irq_n_q  <= &irqst_d;
      if (RD_EN) dout_q <= rd_mux;
      stimer_q <= wr_sel[9];
      potgo_q  <= wr_sel[11];
    end
  end

  assign DATA_OUT   = dout_q;
  assign AUDF       = audf_q;
  assign AUDC       = audc_q;
  assign AUDCTL     = audctl_q;
  assign SKCTL      = skctl_q;
  assign IRQEN      = irqen_q;
  assign IRQ_N      = irq_n_q;
  assign STIMER_STB = stimer_q;
  assign POTGO_STB  = potgo_q;

endmodule

`default_nettype wire

// File: tb/tb_pokey_reg_file.sv
//------------------------------------------------------------------------------
// tb_pokey_reg_file : scoreboard bench for pokey_reg_file with a register-map
//                     reference model; honours POKEY_SERIAL_EN like the DUT.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pokey_reg_file;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  ADDR;
  logic [7:0]  DATA_IN;
  logic        WR_EN, RD_EN;
  logic [7:0]  DATA_OUT;
  logic [31:0] AUDF, AUDC;
  logic [7:0]  AUDCTL, SKCTL, IRQEN, SEROUT_DATA;
  logic        STIMER_STB, SKREST_STB, POTGO_STB, SEROUT_STB;
  logic [7:0]  IRQ_EVENT;
  logic        IRQ_N;
  logic [63:0] POT_IN;
  logic [7:0]  ALLPOT_IN, KBCODE_IN, RANDOM_IN, SERIN_IN, SKSTAT_IN;

  pokey_reg_file dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .DATA_IN(DATA_IN),
    .WR_EN(WR_EN), .RD_EN(RD_EN), .DATA_OUT(DATA_OUT),
    .AUDF(AUDF), .AUDC(AUDC), .AUDCTL(AUDCTL), .SKCTL(SKCTL), .IRQEN(IRQEN),
    .SEROUT_DATA(SEROUT_DATA), .STIMER_STB(STIMER_STB), .SKREST_STB(SKREST_STB),
    .POTGO_STB(POTGO_STB), .SEROUT_STB(SEROUT_STB), .IRQ_EVENT(IRQ_EVENT),
    .IRQ_N(IRQ_N), .POT_IN(POT_IN), .ALLPOT_IN(ALLPOT_IN), .KBCODE_IN(KBCODE_IN),
    .RANDOM_IN(RANDOM_IN), .SERIN_IN(SERIN_IN), .SKSTAT_IN(SKSTAT_IN)
  );

  always #5 CLK = ~CLK;

`ifdef POKEY_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  typedef struct {
    logic [7:0]  dout;
    logic [31:0] audf, audc;
    logic [7:0]  audctl, skctl, irqen, serout;
    logic [3:0]  stb;
    logic        irq_n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: one byte per architectural register.
  logic [7:0] m_audf[4], m_audc[4];
  logic [7:0] m_audctl, m_skctl, m_irqen, m_serout, m_irqst, m_dout;
  logic [3:0] m_stb;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] read_val(input logic [3:0] a);
    case (a)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return POT_IN[a*8 +: 8];
      4'h8: return ALLPOT_IN;
      4'h9: return KBCODE_IN;
      4'hA: return RANDOM_IN;
      4'hD: return SERIAL ? SERIN_IN : 8'hFF;
      4'hE: return m_irqst;
      4'hF: return SERIAL ? SKSTAT_IN : 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_audf[i] = 8'h00; m_audc[i] = 8'h00; end
    m_audctl = 0; m_skctl = 0; m_irqen = 0; m_serout = 0;
    m_irqst = 8'hFF; m_dout = 8'hFF; m_stb = 4'b0000;
  endtask

  task automatic push_exp();
    exp_t e;
    e.dout = m_dout;
    e.audf = {m_audf[3], m_audf[2], m_audf[1], m_audf[0]};
    e.audc = {m_audc[3], m_audc[2], m_audc[1], m_audc[0]};
    e.audctl = m_audctl; e.skctl = m_skctl; e.irqen = m_irqen; e.serout = m_serout;
    e.stb = m_stb;
    e.irq_n = (m_irqst == 8'hFF);
    q.push_back(e);
  endtask

  // One bus cycle: drive at the negedge, predict the state after the next posedge.
  task automatic cyc(input logic wr, input logic rd, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] ev);
    logic [7:0] old_en;
    RESET_N = 1'b1;
    WR_EN = wr; RD_EN = rd; ADDR = a; DATA_IN = d; IRQ_EVENT = ev;
    old_en = m_irqen;
    if (rd) m_dout = read_val(a);
    m_stb = 4'b0000;
    if (wr) begin
      if (a <= 4'h7) begin
        if (a[0]) m_audc[a >> 1] = d; else m_audf[a >> 1] = d;
      end
      case (a)
        4'h8: m_audctl = d;
        4'h9: m_stb[3] = 1'b1;
        4'hA: m_stb[2] = SERIAL;
        4'hB: m_stb[1] = 1'b1;
        4'hD: begin if (SERIAL) m_serout = d; m_stb[0] = SERIAL; end
        4'hE: m_irqen = d;
        4'hF: m_skctl = d;
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      if (!m_irqen[i])             m_irqst[i] = 1'b1;
      else if (ev[i] && old_en[i]) m_irqst[i] = 1'b0;
    end
    push_exp();
    @(negedge CLK);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
  endtask

  // Reset asserted shortly after the posedge, killing any strobe launched there.
  task automatic reset_mid();
    WR_EN = 0; RD_EN = 0; IRQ_EVENT = 0;
    model_reset();
    push_exp();
    @(posedge CLK);
    #1 RESET_N = 1'b0;
    @(negedge CLK);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("DATA_OUT", {24'h0, DATA_OUT}, {24'h0, e.dout});
        chk("AUDF", AUDF, e.audf);
        chk("AUDC", AUDC, e.audc);
        chk("AUDCTL", {24'h0, AUDCTL}, {24'h0, e.audctl});
        chk("SKCTL", {24'h0, SKCTL}, {24'h0, e.skctl});
        chk("IRQEN", {24'h0, IRQEN}, {24'h0, e.irqen});
        chk("SEROUT_DATA", {24'h0, SEROUT_DATA}, {24'h0, e.serout});
        chk("STROBES", {28'h0, STIMER_STB, SKREST_STB, POTGO_STB, SEROUT_STB},
            {28'h0, e.stb});
        chk("IRQ_N", {31'h0, IRQ_N}, {31'h0, e.irq_n});
      end
    end
  end

  initial begin : stimulus
    RESET_N = 1'b0; WR_EN = 0; RD_EN = 0; ADDR = 0; DATA_IN = 0; IRQ_EVENT = 0;
    POT_IN = {$urandom, $urandom}; ALLPOT_IN = 8'h11; KBCODE_IN = 8'h22;
    RANDOM_IN = 8'h33; SERIN_IN = 8'h44; SKSTAT_IN = 8'h55;
    model_reset();
    @(negedge CLK);
    push_exp();
    @(negedge CLK);

    cyc(1, 0, 4'h2, 8'h5A, 8'h00); idle();
    cyc(1, 0, 4'h9, 8'hA5, 8'h00); cyc(1, 0, 4'hB, 8'h3C, 8'h00); idle();
    POT_IN[23:16] = 8'h42;
    cyc(0, 1, 4'h2, 8'h00, 8'h00); idle();
    cyc(0, 1, 4'hB, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'hE, 8'h01, 8'h00); cyc(0, 0, 4'h0, 8'h00, 8'h03);
    cyc(0, 1, 4'hE, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'hE, 8'h00, 8'h00); cyc(0, 1, 4'hE, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'hE, 8'h01, 8'h00); cyc(1, 0, 4'hE, 8'h00, 8'h01);
    cyc(0, 1, 4'hE, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'hD, 8'h77, 8'h00); reset_mid(); idle();
    cyc(0, 1, 4'hF, 8'h00, 8'h00); cyc(0, 1, 4'hD, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'h9, 8'h00, 8'h00); cyc(1, 0, 4'h9, 8'h00, 8'h00);
    cyc(1, 0, 4'hA, 8'h00, 8'h00); cyc(1, 0, 4'hA, 8'h00, 8'h00); idle();
    cyc(1, 0, 4'hE, 8'hFF, 8'h00); cyc(0, 0, 4'h0, 8'h00, 8'h81);
    cyc(1, 1, 4'hE, 8'h00, 8'h00); cyc(0, 1, 4'hE, 8'h00, 8'h00); idle();

    for (int n = 0; n < 600; n++) begin
      POT_IN    = {$urandom, $urandom};
      ALLPOT_IN = 8'($urandom); KBCODE_IN = 8'($urandom); RANDOM_IN = 8'($urandom);
      SERIN_IN  = 8'($urandom); SKSTAT_IN = 8'($urandom);
      if ($urandom_range(0, 99) == 0) reset_mid();
      else cyc(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    idle(); idle();
    @(negedge CLK);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
